// File: rtl/display_mux_dois_digitos.sv
// Two-digit common-anode 7-segment multiplexer with dead-time between slots.
// Digits load on carrega and apply only at an APAGA->MOSTRA boundary. Optional: BLANK_ZERO_EN.
module display_mux_dois_digitos #(
    parameter int DIVISOR = 50000,
    parameter int APAGADO = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [3:0] unidade,
    input  logic [3:0] dezena,
    output logic [6:0] segmentos,
    output logic [1:0] habilita,
    output logic       pendente
);

    localparam int MAXC = (DIVISOR > APAGADO) ? DIVISOR : APAGADO;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] FIM_MOSTRA = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] FIM_APAGA  = CW'(APAGADO - 1);

    typedef enum logic [1:0] {
        MOSTRA_UNID = 2'd0,
        APAGA_1     = 2'd1,
        MOSTRA_DEZ  = 2'd2,
        APAGA_2     = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [3:0]    pend_unid_q, pend_unid_d;
    logic [3:0]    pend_dez_q, pend_dez_d;
    logic [3:0]    ativo_unid_q, ativo_unid_d;
    logic [3:0]    ativo_dez_q, ativo_dez_d;
    logic          pendente_q, pendente_d;
    logic [6:0]    segmentos_q, segmentos_d;
    logic [1:0]    habilita_q, habilita_d;
    logic          fim;
    logic          fronteira;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h06;
        endcase
        return s;
    endfunction

    always_comb begin
        estado_d     = estado_q;
        cont_d       = cont_q + 1'b1;
        pend_unid_d  = pend_unid_q;
        pend_dez_d   = pend_dez_q;
        ativo_unid_d = ativo_unid_q;
        ativo_dez_d  = ativo_dez_q;
        pendente_d   = pendente_q;
        segmentos_d  = 7'h7F;
        habilita_d   = 2'b11;

        if (estado_q == MOSTRA_UNID || estado_q == MOSTRA_DEZ)
            fim = (cont_q == FIM_MOSTRA);
        else
            fim = (cont_q == FIM_APAGA);
        fronteira = fim && (estado_q == APAGA_1 || estado_q == APAGA_2);

        if (fim) begin
            cont_d = '0;
            case (estado_q)
                MOSTRA_UNID: estado_d = APAGA_1;
                APAGA_1:     estado_d = MOSTRA_DEZ;
                MOSTRA_DEZ:  estado_d = APAGA_2;
                default:     estado_d = MOSTRA_UNID;
            endcase
        end

        if (carrega) begin
            pend_unid_d = unidade;
            pend_dez_d  = dezena;
        end

        // A load coinciding with the boundary bypasses the pending regs entirely.
        if (fronteira) begin
            ativo_unid_d = carrega ? unidade : pend_unid_q;
            ativo_dez_d  = carrega ? dezena  : pend_dez_q;
            pendente_d   = 1'b0;
        end else if (carrega) begin
            pendente_d = 1'b1;
        end

        case (estado_q)
            MOSTRA_UNID: begin
                habilita_d  = 2'b10;
                segmentos_d = enc(ativo_unid_q);
            end
            MOSTRA_DEZ: begin
                habilita_d  = 2'b01;
`ifdef BLANK_ZERO_EN
                segmentos_d = (ativo_dez_q == 4'd0) ? 7'h7F : enc(ativo_dez_q);
`else
                segmentos_d = enc(ativo_dez_q);
`endif
            end
            default: begin
                habilita_d  = 2'b11;
                segmentos_d = 7'h7F;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= MOSTRA_UNID;
            cont_q       <= '0;
            pend_unid_q  <= '0;
            pend_dez_q   <= '0;
            ativo_unid_q <= '0;
            ativo_dez_q  <= '0;
            pendente_q   <= 1'b0;
            segmentos_q  <= 7'h7F;
            habilita_q   <= 2'b11;
        end else begin
            estado_q     <= estado_d;
            cont_q       <= cont_d;
            pend_unid_q  <= pend_unid_d;
            pend_dez_q   <= pend_dez_d;
            ativo_unid_q <= ativo_unid_d;
            ativo_dez_q  <= ativo_dez_d;
            pendente_q   <= pendente_d;
            segmentos_q  <= segmentos_d;
            habilita_q   <= habilita_d;
        end
    end

    assign segmentos = segmentos_q;
    assign habilita  = habilita_q;
    assign pendente  = pendente_q;

endmodule
